// File: rtl/opseq_pkg.sv
// Shared opcode encoding, FSM state type and opcode classification helpers
// for the opcode sequencer and the control decoder.
package opseq_pkg;

    localparam logic [5:0] LW_1 = 6'h00;
    localparam logic [5:0] LW_2 = 6'h01;
    localparam logic [5:0] LW_3 = 6'h02;
    localparam logic [5:0] SW_1 = 6'h03;
    localparam logic [5:0] SW_2 = 6'h04;
    localparam logic [5:0] MOV  = 6'h05;
    localparam logic [5:0] RET  = 6'h14;
    localparam logic [5:0] NOP  = 6'h15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        EXPAND = 2'd2,
        TRAP   = 2'd3
    } state_e;

    // Micro-ops still to follow the first step of a fetched instruction.
    function automatic logic [1:0] step_count(input logic [5:0] op);
        case (op)
            LW_1:    return 2'd2;
            SW_1:    return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    // Mid-sequence steps (LW_2, LW_3, SW_2) are never valid as fetched opcodes.
    function automatic logic is_legal(input logic [5:0] op);
        return (op == LW_1) || (op == SW_1) || ((op >= MOV) && (op <= NOP));
    endfunction

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode classifier: legality and number of expansion steps.
module opcode_classify
    import opseq_pkg::*;
(
    input  logic [5:0] opcode_i,
    output logic       legal_o,
    output logic [1:0] remaining_o
);

    assign legal_o     = is_legal(opcode_i);
    assign remaining_o = legal_o ? step_count(opcode_i) : 2'd0;

endmodule

// File: rtl/opcode_sequencer.sv
// Issue stage: accepts fetched words, expands LW/SW into micro-op steps and
// substitutes NOP for illegal opcodes. Define OPSEQ_ILLEGAL_TRAP_EN to make an
// illegal opcode raise a sticky trap that blocks fetch until flush.
module opcode_sequencer
    import opseq_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int OPCODE_LSB = 26
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [5:0]         out_op,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         out_step,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               illegal,
    output logic               trap
);

    state_e             state_q, state_d;
    logic [1:0]         remaining_q, remaining_d;
    logic [5:0]         out_op_q, out_op_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [1:0]         out_step_q, out_step_d;
    logic               out_last_q, out_last_d;
    logic               illegal_q, illegal_d;
    logic               trap_q, trap_d;

    logic [5:0]         in_opcode;
    logic               cls_legal;
    logic [1:0]         cls_remaining;
    logic               busy;
    logic               accept, advance, retire;

    assign in_opcode = in_instr[OPCODE_LSB+5:OPCODE_LSB];

    opcode_classify u_classify (
        .opcode_i    (in_opcode),
        .legal_o     (cls_legal),
        .remaining_o (cls_remaining)
    );

    assign busy    = (state_q == ISSUE) || (state_q == EXPAND);
    assign accept  = in_valid && in_ready;
    assign advance = busy && out_ready && !out_last_q;
    assign retire  = busy && out_ready && out_last_q && !accept;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= 2'd0;
            out_op_q    <= NOP;
            out_instr_q <= '0;
            out_step_q  <= 2'd0;
            out_last_q  <= 1'b0;
            illegal_q   <= 1'b0;
            trap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            out_op_q    <= out_op_d;
            out_instr_q <= out_instr_d;
            out_step_q  <= out_step_d;
            out_last_q  <= out_last_d;
            illegal_q   <= illegal_d;
            trap_q      <= trap_d;
        end
    end

    // NOTE: every variable gets a default before the priority chain, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        out_op_d    = out_op_q;
        out_instr_d = out_instr_q;
        out_step_d  = out_step_q;
        out_last_d  = out_last_q;
        illegal_d   = 1'b0;
        trap_d      = trap_q;

        if (flush) begin
            state_d     = IDLE;
            remaining_d = 2'd0;
            out_last_d  = 1'b0;
            trap_d      = 1'b0;
        end else if (accept) begin
            out_instr_d = in_instr;
            out_op_d    = cls_legal ? in_opcode : NOP;
            out_step_d  = 2'd0;
            remaining_d = cls_remaining;
            out_last_d  = (cls_remaining == 2'd0);
            illegal_d   = !cls_legal;
            state_d     = (cls_remaining != 2'd0) ? EXPAND : ISSUE;
`ifdef OPSEQ_ILLEGAL_TRAP_EN
            trap_d      = trap_q || !cls_legal;
`endif
        end else if (advance) begin
            out_op_d    = out_op_q + 6'd1;
            out_step_d  = out_step_q + 2'd1;
            remaining_d = remaining_q - 2'd1;
            out_last_d  = (remaining_q == 2'd1);
            state_d     = (remaining_q == 2'd1) ? ISSUE : EXPAND;
        end else if (retire) begin
            // The trapped NOP retires into TRAP so fetch stays blocked.
            state_d     = trap_q ? TRAP : IDLE;
        end
    end

    always_comb begin
        out_valid = busy;
        out_op    = out_op_q;
        out_instr = out_instr_q;
        out_step  = out_step_q;
        out_last  = out_last_q;
        illegal   = illegal_q;
        trap      = trap_q;
        in_ready  = !rst && !flush && !trap_q && (!busy || (out_ready && out_last_q));
    end

endmodule

// File: doc/opcode_sequencer.md
# opcode_sequencer

Issue stage placed between instruction fetch and the control decoder. Accepts one 32-bit instruction per valid/ready handshake, checks the 6-bit opcode field and drives a registered micro-op stream to the decoder. Multi-step memory instructions are expanded in hardware: LW_1 becomes LW_1→LW_2→LW_3 and SW_1 becomes SW_1→SW_2. Handles downstream stalls, branch flush and illegal-opcode handling.

## Interface
- INSTR_W, 32, instruction word width
- OPCODE_LSB, 26, LSB of the 6-bit opcode field; the field is [OPCODE_LSB+5:OPCODE_LSB]
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_instr  in  INSTR_W  fetched instruction word
- in_valid  in  1  fetch holds a valid word
- in_ready  out  1  sequencer accepts in_instr this cycle
- flush  in  1  branch or jump taken; discard all in-flight work
- out_op  out  6  micro-opcode presented to the control decoder
- out_instr  out  INSTR_W  accepted word with its operand fields, held for every step of the instruction
- out_step  out  2  index of the current micro-op within its instruction (0..2)
- out_last  out  1  current micro-op is the final step
- out_valid  out  1  out_* fields are valid
- out_ready  in  1  decoder consumes the micro-op this cycle
- illegal  out  1  one-cycle pulse, aligned with first out_valid of an illegal instruction
- trap  out  1  sticky illegal-instruction trap; tied 0 when the trap feature is compiled out

## Operation
- Opcode encoding: LW_1=0x00, LW_2=0x01, LW_3=0x02, SW_1=0x03, SW_2=0x04, MOV..RET=0x05..0x14, NOP=0x15.
- Legal fetched opcodes: 0x00, 0x03, 0x05..0x15. Illegal: 0x01, 0x02, 0x04 (mid-sequence steps must not be fetched directly), and anything above 0x15.
- Acceptance takes place when in_valid && in_ready. On acceptance:
  - out_instr ← in_instr; out_step ← 0; out_valid ← 1.
  - Legal opcode: out_op ← the fetched opcode.
  - Illegal opcode: out_op ← NOP, out_last ← 1, and illegal pulses.
  - Remaining steps: LW_1 → 2, SW_1 → 1, all other opcodes → 0. out_last ← (remaining == 0).
- Advancing: when out_valid && out_ready && !out_last:
  - out_op ← out_op + 1; out_step ← out_step + 1; remaining decrements; out_last is set when remaining reaches 0.
  - out_instr is unchanged.
- Retiring: when out_valid && out_ready && out_last and no new acceptance, out_valid ← 0.
- Readiness: in_ready = !rst && !flush && !trap && (!out_valid || (out_ready && out_last)).
- FSM states:
  - IDLE: out_valid=0.
  - ISSUE: out_valid=1 and remaining=0.
  - EXPAND: out_valid=1 and remaining>0.
  - TRAP: only with the trap feature.
- Transitions:
  - IDLE→ISSUE or EXPAND on accept.
  - EXPAND→EXPAND or ISSUE on advance.
  - ISSUE→IDLE on retire.
  - ISSUE→ISSUE or EXPAND on back-to-back accept.
  - Any state→IDLE on flush.
- Boundary cases:
  - out_ready low: every out_* field is held stable. Fetch is back-pressured during expansion and while stalled.
  - flush: highest priority after rst. Next cycle out_valid=0 and remaining=0. A handshake occurring in the flush cycle is discarded. No acceptance happens in the flush cycle. A half-issued LW or SW is abandoned.
  - rst mid-expansion: all state returns to reset values on the next edge.

## Timing
- Reset values: out_valid 0, out_op 0x15 (NOP), out_instr 0, out_step 0, out_last 0, illegal 0, trap 0.
- Latency: acceptance at edge N → out_valid from cycle N+1. Outputs are fully registered; in_ready is combinational from out_ready, flush and state.
- Throughput: one single-step instruction per cycle. LW occupies 3 decoder cycles, SW occupies 2, assuming out_ready stays high.
- illegal is high exactly one cycle: the cycle the NOP substitute first appears.

## Configuration
- OPSEQ_ILLEGAL_TRAP_EN defined:
  - An illegal acceptance sets trap on the same edge that produces the NOP.
  - While trap=1, in_ready=0. The issued NOP still retires normally.
  - trap clears only on flush or rst.
- OPSEQ_ILLEGAL_TRAP_EN undefined:
  - trap is constant 0.
  - Illegal opcodes become a NOP plus the illegal pulse, and fetch continues uninterrupted.

## Structure
- Package opseq_pkg holds:
  - The opcode localparams LW_1..NOP.
  - The FSM state enum.
  - The step-count function (opcode → remaining steps).
  - The legality function.
- The control decoder imports the same constants, so the encoding is defined in one place.
- One combinational sub-module, opcode_classify: opcode → {legal, remaining[1:0]}. Instantiated once on the in_instr opcode field.

## Test plan
- Back-to-back ADD(0x06), SUB(0x07), NOP with out_ready=1 → out_op 06,07,15 on consecutive cycles, out_last=1 each, in_ready held 1.
- LW_1 accepted, then MOV pending → out_op 00,01,02 with out_step 0,1,2 and out_last only on step 2; in_ready=0 for 2 cycles; MOV appears the cycle after LW_3.
- SW_1 with out_ready low for 3 cycles after the first step → SW_1 held stable for 3 cycles, then SW_2, then out_valid=0.
- flush asserted during LW_2 → next cycle out_valid=0; out_instr is not re-issued; the following fetch is accepted 1 cycle after flush deasserts.
- Fetch opcode 0x02, then 0x3F → out_op=0x15 with illegal pulsed once for each. With OPSEQ_ILLEGAL_TRAP_EN, trap=1 after the first, in_ready=0 until flush.
- rst asserted mid-LW (step 1) → next cycle all outputs at reset values; an LW_1 accepted after rst deasserts restarts at step 0.
